// File: rtl/pm_loader_if.sv
// Host byte link and PM write port of the program-memory boot loader.
// The slave modport is the loader side; the master modport is the host/memory side.
interface pm_loader_if #(
  parameter int PMA_SIZE = 16,
  parameter int PMD_SIZE = 32
);
  logic [7:0]          hst_dt;
  logic                hst_vld;
  logic                ld_hst_rdy;
  logic                ld_pm_cslt;
  logic                ld_pm_wrb;
  logic [PMA_SIZE-1:0] ld_pm_add;
  logic [PMD_SIZE-1:0] ld_pm_dt;
  logic                ld_ps_hold;
  logic                ld_done;
  logic                ld_err;

  modport slave (
    input  hst_dt, hst_vld,
    output ld_hst_rdy, ld_pm_cslt, ld_pm_wrb, ld_pm_add, ld_pm_dt,
           ld_ps_hold, ld_done, ld_err
  );

  modport master (
    output hst_dt, hst_vld,
    input  ld_hst_rdy, ld_pm_cslt, ld_pm_wrb, ld_pm_add, ld_pm_dt,
           ld_ps_hold, ld_done, ld_err
  );
endinterface

// File: rtl/pm_loader.sv
// Boot-time program memory loader: assembles host bytes into PM words, writes them,
// verifies an XOR checksum and keeps the program sequencer held until the image is good.
module pm_loader #(
  parameter int                  PMA_SIZE  = 16,
  parameter int                  PMD_SIZE  = 32,
  parameter logic [PMA_SIZE-1:0] START_ADD = '0
) (
  input  logic           clk,
  input  logic           reset,
  pm_loader_if.slave     bus
);

  localparam int WB   = PMD_SIZE / 8;
  localparam int IDXW = (WB > 1) ? $clog2(WB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WB - 1);

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [15:0]         count;
  logic [IDXW-1:0]     byte_idx;
  logic [PMD_SIZE-1:0] shift_reg;
  logic [PMD_SIZE-1:0] word_reg;
  logic [PMD_SIZE-1:0] shift_nxt;
  logic [7:0]          chk;
  logic [PMA_SIZE-1:0] addr;

  logic rdy;
  logic cslt;
  logic wrb;
  logic hold;
  logic done;
  logic err;

  always_ff @(posedge clk) begin
    if (reset) state <= CNT_HI;
    else       state <= state_nxt;
  end

  // Outputs depend on state only; the host inputs only steer the next state.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    cslt      = 1'b0;
    wrb       = 1'b0;
    hold      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      CNT_HI: begin
        rdy = 1'b1;
        if (bus.hst_vld) state_nxt = CNT_LO;
      end
      CNT_LO: begin
        rdy = 1'b1;
        if (bus.hst_vld) state_nxt = ({count[15:8], bus.hst_dt} == 16'd0) ? CHK : DATA;
      end
      DATA: begin
        rdy = 1'b1;
        if (bus.hst_vld && byte_idx == LAST_IDX) state_nxt = WRITE;
      end
      WRITE: begin
        cslt      = 1'b1;
        wrb       = 1'b1;
        state_nxt = (count == 16'd1) ? CHK : DATA;
      end
      CHK: begin
        rdy = 1'b1;
        if (bus.hst_vld) state_nxt = (bus.hst_dt == chk) ? DONE : ERR;
      end
      DONE: begin
        hold = 1'b0;
        done = 1'b1;
      end
      ERR: begin
        err = 1'b1;
      end
      default: state_nxt = CNT_HI;
    endcase
  end

  assign shift_nxt = (shift_reg << 8) | PMD_SIZE'(bus.hst_dt);

  // word_reg only changes when a word completes, so the PM data bus stays stable between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      word_reg  <= '0;
      chk       <= '0;
      addr      <= START_ADD;
    end else begin
      case (state)
        CNT_HI: if (bus.hst_vld) count[15:8] <= bus.hst_dt;
        CNT_LO: if (bus.hst_vld) begin
          count[7:0] <= bus.hst_dt;
          byte_idx   <= '0;
        end
        DATA: if (bus.hst_vld) begin
          shift_reg <= shift_nxt;
          chk       <= chk ^ bus.hst_dt;
          if (byte_idx == LAST_IDX) begin
            byte_idx <= '0;
            word_reg <= shift_nxt;
          end else begin
            byte_idx <= byte_idx + IDXW'(1);
          end
        end
        WRITE: begin
          addr  <= addr + PMA_SIZE'(1);
          count <= count - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ld_hst_rdy = rdy;
  assign bus.ld_pm_cslt = cslt;
  assign bus.ld_pm_wrb  = wrb;
  assign bus.ld_pm_add  = addr;
  assign bus.ld_pm_dt   = word_reg;
  assign bus.ld_ps_hold = hold;
  assign bus.ld_done    = done;
  assign bus.ld_err     = err;

endmodule
